// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job sequencer and its operand FIFO.
package gcd_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1024;
    localparam int CNT_W       = $clog2(DEF_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_START  = 3'd2,
        S_LOAD_A = 3'd3,
        S_LOAD_B = 3'd4,
        S_WAIT   = 3'd5,
        S_RESULT = 3'd6
    } gcd_state_e;

    // Counter width never drops below the default so small TIMEOUT values stay well-formed.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w > CNT_W) ? w : CNT_W;
    endfunction

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Job input, GCD core and result handshake signals bundled for the sequencer.
interface gcd_job_sequencer_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             core_rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [WIDTH-1:0] core_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, done, core_result, res_ready,
        input  in_ready, core_rst, start, data_in, res_valid, res_data, res_err, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, done, core_result, res_ready,
        output in_ready, core_rst, start, data_in, res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Small synchronous FIFO holding operand pairs; head is readable combinationally.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds queued operand pairs to a subtractive GCD core and returns results,
// with a zero-operand bypass and a WAIT-state timeout.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    gcd_job_sequencer_if.slave  bus
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    gcd_state_e         r_state;
    logic               r_core_rst;
    logic               r_start;
    logic [WIDTH-1:0]   r_data_in;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_err;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass;

    assign w_push   = bus.in_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_head_a = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b = w_head[WIDTH-1:0];
    assign w_bypass = (w_head_a == '0) || (w_head_b == '0);

    gcd_pair_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({bus.in_a, bus.in_b}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.in_ready  = !w_full;
    assign bus.core_rst  = r_core_rst;
    assign bus.start     = r_start;
    assign bus.data_in   = r_data_in;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_a <= w_head_a;
            r_b <= w_head_b;
        end
    end

    // Output registers are set on the edge entering each state, so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_core_rst  <= 1'b0;
            r_start     <= 1'b0;
            r_data_in   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        if (w_bypass) begin
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_head_a | w_head_b;
                            r_res_err   <= 1'b0;
                            r_state     <= S_RESULT;
                        end else begin
                            r_core_rst  <= 1'b1;
                            r_state     <= S_CRST;
                        end
                    end
                end
                S_CRST: begin
                    r_core_rst <= 1'b0;
                    r_start    <= 1'b1;
                    r_data_in  <= '0;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_data_in <= r_a;
                    r_state   <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    r_data_in <= r_b;
                    r_state   <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                // done wins over an expiring counter in the same cycle.
                S_WAIT: begin
                    if (bus.done) begin
                        r_res_data  <= bus.core_result;
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= S_RESULT;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream feeder for the subtractive GCD core (datapath plus controller pair).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Per job: pulses a core reset, raises start, presents A then B serially on the core's shared data_in bus, waits for done, then returns the result (core A-register output) over a valid/ready result port.
- Adds a cycle-count timeout and a zero-operand bypass, so the core is never started on a non-terminating input.

Parameters:
- WIDTH, 16, operand and result width.
- DEPTH, 4, operand-pair FIFO depth; power of 2, at least 2.
- TIMEOUT, 1024, maximum WAIT-state cycles before the job is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- core_rst  out  1  one-cycle reset pulse to the GCD core.
- start  out  1  GCD controller start.
- data_in  out  WIDTH  serial operand bus to the GCD datapath.
- done  in  1  GCD controller done; level, held until core reset.
- core_result  in  WIDTH  GCD datapath A-register output.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  WIDTH  GCD result.
- res_err  out  1  timeout flag for this result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - outputs: in_ready=1, core_rst=0, start=0, data_in=0, res_valid=0, res_data=0, res_err=0, busy=0.
  - internal: FIFO empty, timeout counter 0, FSM in IDLE.
  - Reset mid-job abandons the job and all FIFO contents.
- FIFO:
  - Push when in_valid && in_ready. Pop only in IDLE on dispatch.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - in_ready = (count != DEPTH). Pointers wrap modulo DEPTH.
- FSM states: IDLE, CRST, START, LOAD_A, LOAD_B, WAIT, RESULT.
- IDLE: if FIFO non-empty, pop the head into a_reg/b_reg.
  - If a_reg==0 or b_reg==0: go to RESULT with res_data = a|b and res_err=0. The core is not touched.
  - Otherwise go to CRST.
- CRST: core_rst=1 for exactly one cycle; then START.
- START: start=1, held through WAIT; data_in=0; then LOAD_A.
- LOAD_A: data_in=a_reg for one cycle; then LOAD_B.
- LOAD_B: data_in=b_reg for one cycle; then WAIT.
  - A is on the bus exactly 2 cycles after core_rst; B exactly 3 cycles after.
- WAIT: data_in holds b_reg; counter increments each cycle.
  - If done==1: capture core_result into res_data, res_err=0, go to RESULT.
  - Else if counter reaches TIMEOUT-1: res_data=0, res_err=1, go to RESULT.
  - done takes priority when both occur in the same cycle.
  - done is ignored in every state except WAIT.
- RESULT: start=0, res_valid=1. res_data and res_err stay stable until res_ready is sampled high; then res_valid=0 and go to IDLE.
  - No back-to-back dispatch in the handshake cycle; minimum one IDLE cycle between jobs.
- Latency: core path = 3 setup cycles + core compute + 1 capture cycle. Bypass path = 1 cycle from pop to res_valid.
- busy = (state != IDLE).
- All outputs are registered.

Decomposition:
- Package gcd_pkg holds:
  - the FSM state enum (3-bit encoding);
  - localparam CNT_W = $clog2(TIMEOUT);
  - default WIDTH.
- One sub-module, gcd_pair_fifo: WIDTH*2 data, DEPTH entries, synchronous reset, push/pop/full/empty/count.
- The FSM and timeout counter stay in gcd_job_sequencer.

Test Plan:
- Basic job: push (56,98), res_ready=1 -> core_rst pulse; data_in=56 then 98 on consecutive cycles; res_valid with res_data=14, res_err=0.
- Backpressure and queueing: push (12,18), (35,49), (17,5) back-to-back with res_ready=0 -> first result 6 held stable; release res_ready -> results 6, 7, 1 in order; FIFO fill and drain checked.
- Full FIFO: with DEPTH=4, push 5 pairs while the FSM is stalled -> in_ready=0 after the 4th pair; the 5th is accepted only after a pop; no pair lost.
- Zero bypass: push (0,21) -> res_data=21 one cycle after pop; core_rst and start never asserted. Push (0,0) -> res_data=0, res_err=0.
- Timeout: stub core with done tied low, TIMEOUT=16 -> res_err=1, res_data=0 exactly 16 WAIT cycles after LOAD_B; next queued job still runs.
- Reset mid-job: assert rst during WAIT -> all outputs return to reset values next cycle; FIFO empty; a fresh (8,12) job yields 4.
